fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, program-memory address width in bits.
REQ-002 Parameter DATA_W, default 16, instruction width in bits.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles spent in REQ before the fetch is abandoned.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 fetch_req  input  1  core requests an instruction fetch at address pc.
REQ-007 pc  input  ADDR_W  fetch address, sampled only when a fetch_req is accepted.
REQ-008 flush  input  1  abort any in-flight or held fetch.
REQ-009 mem_read_valid  output  1  read request to program memory.
REQ-010 mem_read_address  output  ADDR_W  read address, stable while mem_read_valid is 1.
REQ-011 mem_read_ready  input  1  memory returns data this cycle.
REQ-012 mem_read_data  input  DATA_W  instruction word, valid when mem_read_ready is 1.
REQ-013 instruction  output  DATA_W  registered instruction word presented to the decoder.
REQ-014 instr_valid  output  1  instruction holds a fetched word.
REQ-015 instr_ack  input  1  decoder/core consumes the held instruction.
REQ-016 busy  output  1  1 whenever the state is not IDLE.
REQ-017 fetch_err  output  1  sticky flag: last fetch timed out.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, REQ and VALID.
REQ-019 In IDLE, a fetch_req SHALL be accepted: pc latched into mem_read_address, fetch_err cleared, next state REQ.
REQ-020 In REQ, mem_read_valid SHALL be 1 and mem_read_address SHALL be held constant.
REQ-021 Latency: a fetch_req accepted at edge N SHALL show mem_read_valid=1 from edge N+1.
REQ-022 In REQ, when mem_read_ready=1, mem_read_data SHALL be captured into instruction and the next state SHALL be VALID: instr_valid=1 and mem_read_valid=0 from the following edge.
REQ-023 mem_read_ready SHALL be ignored in IDLE and VALID.
REQ-024 fetch_req SHALL be ignored in REQ; pc changes SHALL then have no effect.
REQ-025 In VALID, instruction SHALL be held stable until instr_ack=1.
REQ-026 In VALID, on instr_ack=1 with fetch_req=0, the next state SHALL be IDLE and instr_valid SHALL drop.
REQ-027 In VALID, on instr_ack=1 with fetch_req=1 (back-to-back), the new pc SHALL be latched, fetch_err cleared and the next state SHALL be REQ.
REQ-028 A fetch_req in VALID without instr_ack SHALL be ignored.
REQ-029 The timeout counter SHALL be ADDR_W-independent, 8 bits wide, cleared on entry to REQ and incremented each cycle in REQ without mem_read_ready.
REQ-030 When the count reaches TIMEOUT without mem_read_ready, the block SHALL load instruction=16'hF000 (HALT), set fetch_err=1 and go to VALID.
REQ-031 A mem_read_ready arriving in the timeout cycle SHALL win: data captured, fetch_err stays 0.
REQ-032 flush=1 in any state SHALL force next state IDLE, with instr_valid=0 and mem_read_valid=0 from the next edge.
REQ-033 flush SHALL take priority over mem_read_ready, fetch_req, instr_ack and timeout; data returned in a flush cycle SHALL be discarded.
REQ-034 flush SHALL leave instruction and fetch_err unchanged.

Reset
REQ-035 rst_n=0 SHALL immediately force state IDLE, with mem_read_valid=0, mem_read_address=0, instruction=0, instr_valid=0, fetch_err=0, busy=0 and timeout count 0, asynchronously and regardless of clk.
REQ-036 Reset asserted mid-REQ or mid-VALID SHALL abandon the fetch; after release the block SHALL stay in IDLE until a new fetch_req.

Verification
REQ-037 Basic fetch: pc=8'h05 with fetch_req pulse, memory ready 3 cycles later with 16'h3123 -> mem_read_valid=1 with address 05 for 3 cycles, then instruction=3123 and instr_valid=1 until instr_ack.
REQ-038 Back-to-back: in VALID, assert instr_ack and fetch_req together with pc=06 -> mem_read_valid=1 with address 06 on the next edge, and instr_valid=0.
REQ-039 Timeout: fetch at pc=10 with ready never asserted -> after 255 REQ cycles instruction=F000, instr_valid=1 and fetch_err=1; the next accepted fetch_req clears fetch_err.
REQ-040 Flush vs ready: in REQ, assert flush and mem_read_ready(data 16'h9A42) in the same cycle -> next edge IDLE, instr_valid=0, and instruction not equal to 9A42.
REQ-041 Ignored inputs: fetch_req with changing pc during REQ, and mem_read_ready pulses in IDLE -> mem_read_address unchanged, and no state change.
REQ-042 Async reset: drop rst_n between clock edges during REQ -> all outputs reach reset values before the next edge; after release, no activity until fetch_req.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: latches a PC, requests program memory, holds the
// returned word for the decoder, substitutes HALT when memory never answers.
module fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              mem_read_valid,
  output logic [ADDR_W-1:0] mem_read_address,
  input  logic              mem_read_ready,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  input  logic              instr_ack,
  output logic              busy,
  output logic              fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, VALID} state_e;

  // The timeout fires in the REQ cycle whose count is TIMEOUT-1, so REQ
  // lasts at most TIMEOUT cycles.
  localparam logic [7:0]        TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] HALT     = DATA_W'(16'hF000);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (flush) begin
      // Abandon the fetch but keep the last word and error flag visible.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fetch_req) begin
            addr_d  = pc;
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = REQ;
          end
        end
        REQ: begin
          if (mem_read_ready) begin
            instr_d = mem_read_data;
            state_d = VALID;
          end else if (cnt_q == TMO_LAST) begin
            instr_d = HALT;
            err_d   = 1'b1;
            state_d = VALID;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        VALID: begin
          if (instr_ack) begin
            if (fetch_req) begin
              addr_d  = pc;
              err_d   = 1'b0;
              cnt_d   = '0;
              state_d = REQ;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign mem_read_valid   = (state_q == REQ);
  assign instr_valid      = (state_q == VALID);
  assign busy             = (state_q != IDLE);
  assign mem_read_address = addr_q;
  assign instruction      = instr_q;
  assign fetch_err        = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: expected words are queued as memory
// responses are driven and checked when instr_valid rises.
module tb_fetch_unit;

  logic        clk, rst_n;
  logic        fetch_req, flush, mem_read_ready, instr_ack;
  logic [7:0]  pc;
  logic [15:0] mem_read_data;
  logic        mem_read_valid, instr_valid, busy, fetch_err;
  logic [7:0]  mem_read_address;
  logic [15:0] instruction;

  typedef struct {
    logic [15:0] instr;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_v;

  fetch_unit #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(255)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_req        (fetch_req),
    .pc               (pc),
    .flush            (flush),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .instruction      (instruction),
    .instr_valid      (instr_valid),
    .instr_ack        (instr_ack),
    .busy             (busy),
    .fetch_err        (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] instr, input logic err);
    exp_t e;
    e.instr = instr;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Monitor: every new instruction presented must match the oldest queued one.
  always @(negedge clk) begin
    if (instr_valid && !prev_v) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr", instruction, e.instr);
        chk("sb_err", fetch_err, e.err);
      end
    end
    prev_v <= instr_valid;
  end

  initial begin
    int n;
    prev_v = 1'b0;
    rst_n = 1'b0; fetch_req = 0; flush = 0; mem_read_ready = 0; instr_ack = 0;
    pc = 8'h00; mem_read_data = 16'h0000;
    #1;
    chk("rst_mrv", mem_read_valid, 0);
    chk("rst_addr", mem_read_address, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_iv", instr_valid, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_busy", busy, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic fetch at 05, memory answers in the third REQ cycle.
    pc = 8'h05; fetch_req = 1; tick(); fetch_req = 0; pc = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      chk("basic_mrv", mem_read_valid, 1);
      chk("basic_addr", mem_read_address, 8'h05);
      if (i == 2) begin
        mem_read_ready = 1; mem_read_data = 16'h3123; push(16'h3123, 0);
      end
      tick();
    end
    mem_read_ready = 0;
    for (int i = 0; i < 2; i++) begin
      chk("basic_iv", instr_valid, 1);
      chk("basic_mrv_off", mem_read_valid, 0);
      chk("basic_hold", instruction, 16'h3123);
      mem_read_ready = 1; mem_read_data = 16'hDEAD;
      fetch_req = 1; pc = 8'h99;
      tick();
      mem_read_ready = 0; fetch_req = 0;
    end
    chk("valid_ignore", instruction, 16'h3123);

    // Back-to-back ack + fetch at 06.
    instr_ack = 1; fetch_req = 1; pc = 8'h06; tick();
    instr_ack = 0; fetch_req = 0;
    chk("b2b_mrv", mem_read_valid, 1);
    chk("b2b_addr", mem_read_address, 8'h06);
    chk("b2b_iv", instr_valid, 0);

    // fetch_req and pc changes in REQ are ignored.
    fetch_req = 1; pc = 8'h77; tick();
    pc = 8'h78; tick();
    fetch_req = 0;
    chk("req_ign_addr", mem_read_address, 8'h06);
    chk("req_ign_mrv", mem_read_valid, 1);
    mem_read_ready = 1; mem_read_data = 16'hA5A5; push(16'hA5A5, 0); tick();
    mem_read_ready = 0;
    instr_ack = 1; tick(); instr_ack = 0;
    chk("ack_idle_busy", busy, 0);
    chk("ack_idle_iv", instr_valid, 0);

    // Ready pulses in IDLE are ignored.
    mem_read_ready = 1; mem_read_data = 16'h1111; tick(); tick();
    mem_read_ready = 0;
    chk("idle_ign_busy", busy, 0);
    chk("idle_ign_instr", instruction, 16'hA5A5);
    chk("idle_ign_addr", mem_read_address, 8'h06);

    // Timeout at pc=10: REQ must last exactly 255 cycles.
    pc = 8'h10; fetch_req = 1; push(16'hF000, 1); tick(); fetch_req = 0;
    n = 0;
    while (mem_read_valid && n < 300) begin n++; tick(); end
    chk("tmo_cycles", n, 255);
    chk("tmo_instr", instruction, 16'hF000);
    chk("tmo_iv", instr_valid, 1);
    chk("tmo_err", fetch_err, 1);
    instr_ack = 1; fetch_req = 1; pc = 8'h11; tick();
    instr_ack = 0; fetch_req = 0;
    chk("tmo_err_clr", fetch_err, 0);
    chk("tmo_next_addr", mem_read_address, 8'h11);

    // Ready in the timeout cycle wins.
    for (int i = 0; i < 254; i++) tick();
    chk("tmo_not_early", mem_read_valid, 1);
    mem_read_ready = 1; mem_read_data = 16'hBEEF; push(16'hBEEF, 0); tick();
    mem_read_ready = 0;
    chk("tmo_win_iv", instr_valid, 1);
    chk("tmo_win_err", fetch_err, 0);

    // Flush beats a same-cycle ready; returned data is dropped.
    instr_ack = 1; tick(); instr_ack = 0;
    pc = 8'h20; fetch_req = 1; tick(); fetch_req = 0;
    flush = 1; mem_read_ready = 1; mem_read_data = 16'h9A42; tick();
    flush = 0; mem_read_ready = 0;
    chk("flush_busy", busy, 0);
    chk("flush_iv", instr_valid, 0);
    chk("flush_mrv", mem_read_valid, 0);
    chk("flush_instr", instruction, 16'hBEEF);
    tick();
    chk("flush_stay_idle", busy, 0);

    // Async reset mid-REQ.
    pc = 8'h33; fetch_req = 1; tick(); fetch_req = 0;
    chk("pre_rst_mrv", mem_read_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_mrv", mem_read_valid, 0);
    chk("arst_addr", mem_read_address, 0);
    chk("arst_instr", instruction, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", fetch_err, 0);
    #2 rst_n = 1;
    mem_read_ready = 1; mem_read_data = 16'h5555;
    tick(); tick(); tick();
    mem_read_ready = 0;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_mrv", mem_read_valid, 0);

    // Recovery fetch.
    pc = 8'h44; fetch_req = 1; tick(); fetch_req = 0;
    chk("rec_addr", mem_read_address, 8'h44);
    mem_read_ready = 1; mem_read_data = 16'h0C0C; push(16'h0C0C, 0); tick();
    mem_read_ready = 0;
    instr_ack = 1; tick(); instr_ack = 0;
    tick();
    chk("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
